// File: rtl/rtc_reg_arbiter.sv
// rtl/rtc_reg_arbiter.sv - round-robin arbiter sharing the RTC register file between core and I2C slave
// Optional macro RTC_ARB_I2C_WRITE_EN: when defined, I2C writes reach the register file.
module rtc_reg_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              i2c_req,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic              i2c_gnt,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_rvalid,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_write_en,
    input  logic [DATA_W-1:0] reg_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_I2C  = 1'b1;

    logic [1:0] state;
    logic       owner;
    logic       last_owner;
    logic       lat_we;
    logic       pick_i2c;
    logic       write_allowed;

    // I2C wins only if alone, or on a tie when the core was granted last.
    assign pick_i2c = i2c_req && (!core_req || (last_owner == OWN_CORE));

`ifdef RTC_ARB_I2C_WRITE_EN
    assign write_allowed = 1'b1;
`else
    // Read-only I2C: the write is still granted so the slave never hangs, but is not committed.
    assign write_allowed = (owner == OWN_CORE);
`endif

    assign core_gnt     = (state == ACCESS) && (owner == OWN_CORE);
    assign i2c_gnt      = (state == ACCESS) && (owner == OWN_I2C);
    assign reg_write_en = (state == ACCESS) && lat_we && write_allowed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_CORE;
            last_owner  <= OWN_I2C;
            lat_we      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            core_rdata  <= '0;
            i2c_rdata   <= '0;
            core_rvalid <= 1'b0;
            i2c_rvalid  <= 1'b0;
        end else begin
            core_rvalid <= 1'b0;
            i2c_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req || i2c_req) begin
                        owner      <= pick_i2c;
                        last_owner <= pick_i2c;
                        state      <= ACCESS;
                        if (pick_i2c) begin
                            lat_we    <= i2c_we;
                            reg_addr  <= i2c_addr;
                            reg_wdata <= i2c_wdata;
                        end else begin
                            lat_we    <= core_we;
                            reg_addr  <= core_addr;
                            reg_wdata <= core_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state <= lat_we ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    state <= IDLE;
                    if (owner == OWN_I2C) begin
                        i2c_rdata  <= reg_rdata;
                        i2c_rvalid <= 1'b1;
                    end else begin
                        core_rdata  <= reg_rdata;
                        core_rvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_reg_arbiter.sv
// tb/tb_rtc_reg_arbiter.sv - directed self-checking bench for rtc_reg_arbiter
module tb_rtc_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_req, core_we, core_gnt, core_rvalid;
    logic [3:0] core_addr;
    logic [7:0] core_wdata, core_rdata;
    logic       i2c_req, i2c_we, i2c_gnt, i2c_rvalid;
    logic [3:0] i2c_addr;
    logic [7:0] i2c_wdata, i2c_rdata;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;
    logic       reg_write_en;

    logic [7:0] mem [16];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rtc_reg_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_gnt(i2c_gnt), .i2c_rdata(i2c_rdata), .i2c_rvalid(i2c_rvalid),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write_en(reg_write_en),
        .reg_rdata(reg_rdata)
    );

    // Register file model with synchronous read.
    always @(posedge clk) begin
        if (reg_write_en) mem[reg_addr] <= reg_wdata;
        reg_rdata <= mem[reg_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, core_gnt, i2c_gnt}, 0);
        chk({tag, "_rvalid"}, {30'd0, core_rvalid, i2c_rvalid}, 0);
        chk({tag, "_wen"}, {31'd0, reg_write_en}, 0);
        chk({tag, "_bus"}, {20'd0, reg_addr, reg_wdata}, 0);
        chk({tag, "_rdata"}, {16'd0, core_rdata, i2c_rdata}, 0);
    endtask

    logic exp_i2c_wr;
    logic prev_g, g;
    int   ng;

    initial begin
`ifdef RTC_ARB_I2C_WRITE_EN
        exp_i2c_wr = 1'b1;
`else
        exp_i2c_wr = 1'b0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rst = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        i2c_req = 0; i2c_we = 0; i2c_addr = 0; i2c_wdata = 0;
        step(); step();
        rst = 1'b0;
        chk_all_zero("reset");

        // Core write alone
        core_req = 1; core_we = 1; core_addr = 4'd0; core_wdata = 8'h0A;
        step();
        chk("cw_gnt", {31'd0, core_gnt}, 1);
        chk("cw_i2c_gnt", {31'd0, i2c_gnt}, 0);
        chk("cw_wen", {31'd0, reg_write_en}, 1);
        chk("cw_bus", {20'd0, reg_addr, reg_wdata}, {20'd0, 4'd0, 8'h0A});
        core_req = 0;
        step();
        chk("cw_idle", {30'd0, core_gnt, reg_write_en}, 0);

        // I2C read of the register just written
        i2c_req = 1; i2c_we = 0; i2c_addr = 4'd0;
        step();
        chk("ir_gnt", {30'd0, i2c_gnt, reg_write_en}, 2'b10);
        i2c_req = 0;
        step();
        chk("ir_rdwait", {29'd0, i2c_rvalid, reg_write_en, i2c_gnt}, 0);
        step();
        chk("ir_rvalid", {31'd0, i2c_rvalid}, 1);
        chk("ir_rdata", {24'd0, i2c_rdata}, 8'h0A);
        chk("ir_core_rvalid", {31'd0, core_rvalid}, 0);
        step();
        chk("ir_pulse", {31'd0, i2c_rvalid}, 0);
        chk("ir_hold", {24'd0, i2c_rdata}, 8'h0A);

        // Tie after reset: core write wins, I2C reads new value
        rst = 1; step(); rst = 0;
        core_req = 1; core_we = 1; core_addr = 4'd1; core_wdata = 8'h0F;
        i2c_req = 1; i2c_we = 0; i2c_addr = 4'd1;
        step();
        chk("tie1_gnt", {30'd0, core_gnt, i2c_gnt}, 2'b10);
        core_req = 0;
        step();
        chk("tie1_idle", {30'd0, core_gnt, i2c_gnt}, 0);
        step();
        chk("tie1_i2c_gnt", {31'd0, i2c_gnt}, 1);
        i2c_req = 0;
        step(); step();
        chk("tie1_rvalid", {31'd0, i2c_rvalid}, 1);
        chk("tie1_rdata", {24'd0, i2c_rdata}, 8'h0F);

        // Core single write, then a tie: I2C wins round-robin
        core_req = 1; core_we = 1; core_addr = 4'd3; core_wdata = 8'h33;
        step();
        chk("cw3_gnt", {31'd0, core_gnt}, 1);
        core_req = 0;
        step();
        core_req = 1; core_we = 0; core_addr = 4'd3;
        i2c_req = 1; i2c_we = 0; i2c_addr = 4'd3;
        step();
        chk("tie2_gnt", {30'd0, core_gnt, i2c_gnt}, 2'b01);
        i2c_req = 0;
        step();
        chk("tie2_rdwait", {31'd0, core_gnt}, 0);
        step();
        chk("tie2_i2c_rv", {23'd0, i2c_rvalid, i2c_rdata}, {23'd0, 1'b1, 8'h33});
        chk("tie2_core_wait", {31'd0, core_gnt}, 0);
        step();
        chk("tie2_core_gnt", {31'd0, core_gnt}, 1);
        core_req = 0;
        step(); step();
        chk("tie2_core_rv", {23'd0, core_rvalid, core_rdata}, {23'd0, 1'b1, 8'h33});

        // Fairness: both re-request as soon as allowed
        rst = 1; step(); rst = 0;
        core_req = 1; core_we = 1; core_addr = 4'd4; core_wdata = 8'h44;
        i2c_req = 1; i2c_we = 0; i2c_addr = 4'd4;
        ng = 0; prev_g = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (core_gnt || i2c_gnt) begin
                g = i2c_gnt;
                if (ng == 0) chk("fair_first", {31'd0, g}, 0);
                else chk("fair_alt", {31'd0, g}, {31'd0, !prev_g});
                prev_g = g;
                ng++;
            end
            core_req = !core_gnt;
            i2c_req  = !i2c_gnt;
        end
        chk("fair_count", ng, 7);
        core_req = 0; i2c_req = 0;
        step(); step(); step(); step();

        // Reset in RDWAIT drops the read
        core_req = 1; core_we = 0; core_addr = 4'd0;
        step();
        chk("rr_gnt", {31'd0, core_gnt}, 1);
        core_req = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        chk_all_zero("rr_reset");
        step();
        chk("rr_no_rvalid", {31'd0, core_rvalid}, 0);
        core_req = 1; core_we = 0; core_addr = 4'd0;
        i2c_req = 1; i2c_we = 0; i2c_addr = 4'd0;
        step();
        chk("rr_tie", {30'd0, core_gnt, i2c_gnt}, 2'b10);
        core_req = 0;
        step(); step();
        chk("rr_core_rv", {23'd0, core_rvalid, core_rdata}, {23'd0, 1'b1, 8'h0A});
        step();
        chk("rr_i2c_gnt", {31'd0, i2c_gnt}, 1);
        i2c_req = 0;
        step(); step();

        // I2C write: committed only with the write-enable build option
        i2c_req = 1; i2c_we = 1; i2c_addr = 4'd2; i2c_wdata = 8'h55;
        step();
        chk("iw_gnt", {31'd0, i2c_gnt}, 1);
        chk("iw_wen", {31'd0, reg_write_en}, {31'd0, exp_i2c_wr});
        i2c_req = 0;
        step();
        chk("iw_idle", {30'd0, i2c_rvalid, i2c_gnt}, 0);
        step();
        chk("iw_no_rvalid", {31'd0, i2c_rvalid}, 0);
        chk("iw_mem", {24'd0, mem[2]}, exp_i2c_wr ? 32'h55 : 32'h00);
        core_req = 1; core_we = 0; core_addr = 4'd2;
        step();
        core_req = 0;
        step(); step();
        chk("iw_readback", {23'd0, core_rvalid, core_rdata},
            {23'd0, 1'b1, (exp_i2c_wr ? 8'h55 : 8'h00)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_reg_arbiter.md
# rtc_reg_arbiter

Sequenced arbiter that shares the RTC register file between two requesters: the timekeeping core and the I2C slave. Each requester uses a req/gnt handshake. The arbiter serialises accesses, drives the register-file address, write-data and write-enable bus, and returns read data with a valid pulse. It replaces direct muxing of the two ports, so a core write and an I2C access can never collide on the same cycle.

## Interface
- ADDR_W, 4, register-file address width
- DATA_W, 8, register data width

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  core access request, held until core_gnt
- core_we  in  1  1 = write, 0 = read; stable while core_req
- core_addr  in  ADDR_W  core target register
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  one-cycle grant pulse
- core_rdata  out  DATA_W  read data returned to core
- core_rvalid  out  1  one-cycle pulse, core_rdata valid
- i2c_req, i2c_we, i2c_addr, i2c_wdata, i2c_gnt, i2c_rdata, i2c_rvalid  same as core_* for the I2C slave
- reg_addr  out  ADDR_W  register-file address
- reg_wdata  out  DATA_W  register-file write data
- reg_write_en  out  1  register-file write strobe
- reg_rdata  in  DATA_W  register-file read data, valid one cycle after reg_addr (synchronous read)

## Operation
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE, no req: stay. Any req: choose a winner, latch its we/addr/wdata, record the owner, go to ACCESS.
- Arbitration:
  - Single requester wins.
  - Both requesting: the one not granted last wins (round-robin pointer `last_owner`, updated on each grant).
  - Reset sets `last_owner` = I2C, so the core wins the first tie.
- ACCESS:
  - reg_addr/reg_wdata hold the latched values; reg_write_en = latched we.
  - Owner's gnt = 1.
  - Next state: write → IDLE; read → RDWAIT.
- RDWAIT:
  - reg_addr stays held; reg_write_en = 0.
  - Capture reg_rdata into owner's rdata register.
  - Owner's rvalid pulses next cycle; → IDLE.
- Requester rules:
  - Must drop req the cycle after seeing gnt.
  - req still high in IDLE is treated as a new request.
  - Changing we/addr/wdata while req is pending and ungranted is illegal (undefined).
- Non-owner gnt/rvalid stay 0.
- rdata registers hold their last value until the next read by the same requester.
- reg_addr/reg_wdata hold their last values in IDLE; reg_write_en = 0 outside ACCESS.

## Timing
- Reset (rst high at a clock edge):
  - State → IDLE; every output = 0.
  - `last_owner` = I2C.
  - Any in-flight transaction is dropped: no gnt, no rvalid, no write.
- Write (req first sampled in cycle N):
  - ACCESS in N+1: gnt = 1 and reg_write_en = 1.
  - Register file writes at the end of N+1.
  - IDLE in N+2, so the next grant is in N+3 at the earliest.
- Read (req first sampled in cycle N):
  - ACCESS in N+1 (gnt).
  - RDWAIT in N+2 (reg_rdata sampled).
  - rvalid = 1 and rdata valid in N+3, with state IDLE in N+3.
  - A new request in N+3 is granted in N+4.
- Simultaneous requests: the loser's req stays high and it is granted in the next ACCESS after the winner completes. Worst-case wait is one foreign transaction (3 cycles).
- Same-address race: core write and I2C read to the same register, both requesting, core wins → I2C reads the newly written value.

## Configuration
- RTC_ARB_I2C_WRITE_EN:
  - Defined: I2C writes behave exactly like core writes.
  - Undefined: the I2C port is read-only.
    - An I2C request with i2c_we = 1 is still granted (i2c_gnt pulse in ACCESS), so the slave never hangs.
    - reg_write_en stays 0 for that access, no rvalid follows, and the FSM returns to IDLE after ACCESS.
  - Core writes are unaffected either way.

## Test plan
- Core write alone: core_req, we=1, addr=0, wdata=0x0A → next cycle core_gnt=1, reg_write_en=1, reg_addr=0, reg_wdata=0x0A; IDLE after.
- I2C read after that write: i2c_req, we=0, addr=0, register model returns 0x0A → i2c_rvalid pulses 3 cycles after request with i2c_rdata=0x0A; reg_write_en never 1.
- Tie after reset: core write addr=1 data=0x0F and I2C read addr=1 raised together → core granted first; I2C granted next and returns 0x0F. Second tie → I2C wins (round-robin).
- Fairness: core re-requests continuously while I2C holds req → grants alternate core, I2C, core; no requester is granted twice in a row while the other waits.
- Reset mid-read: assert rst in the RDWAIT cycle → no rvalid ever; all outputs 0 next cycle; the next tie goes to the core.
- Macro undefined: I2C write addr=2 data=0x55 → i2c_gnt pulses, reg_write_en stays 0, register 2 unchanged, no i2c_rvalid. With the macro defined: the write lands.
